wave_nco: RTL and testbench
===========================

WAVE_NCO -- requirements
Module: wave_nco

Interface
REQ-001 Parameter PHASE_W, default 16, phase accumulator and tuning-word width; legal range OUT_W..32.
REQ-002 Parameter OUT_W, default 8, signed two's-complement sample width; legal range 4..16.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  accumulator advance enable.
REQ-006 phase_clr  input  1  synchronous phase clear.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_ready  output  1  block can accept a configuration.
REQ-009 cfg_ftw  input  PHASE_W  frequency tuning word offered.
REQ-010 cfg_mode  input  2  waveform offered: 0 triangle, 1 sawtooth, 2 square, 3 reverse sawtooth.
REQ-011 wave_out  output  OUT_W  registered signed sample.
REQ-012 out_valid  output  1  wave_out corresponds to an enabled cycle.
REQ-013 wrap  output  1  one-cycle pulse marking a phase wrap.

Function
REQ-014 Internal registers SHALL be: phase (PHASE_W), act_ftw (PHASE_W), act_mode (2), pend_ftw (PHASE_W), pend_mode (2), and a two-state config FSM EMPTY/PENDING.
REQ-015 Handshake: cfg_ready SHALL be 1 in EMPTY and 0 in PENDING; accept = cfg_valid & cfg_ready; on accept, pend_* load cfg_* and the FSM goes to PENDING.
REQ-016 Phase update priority, per edge: phase_clr -> phase=0; else en -> phase = (phase + act_ftw) mod 2^PHASE_W; else phase holds.
REQ-017 A wrap event SHALL be an edge where en=1, phase_clr=0, and phase + act_ftw carries out of PHASE_W bits; wrap SHALL be 1 for exactly the cycle after that edge.
REQ-018 In PENDING, act_* SHALL load pend_* and the FSM returns to EMPTY on any edge that is a wrap event, or has phase_clr=1, or has en=0; the increment computed on that same edge uses the old act_ftw.
REQ-019 A configuration accepted on an edge SHALL NOT be applied on that same edge, even if that edge is a wrap event.
REQ-020 Sample derivation from registered phase p and act_mode; let T = p[PHASE_W-1 -: OUT_W], q = T[OUT_W-1:OUT_W-2], f = T[OUT_W-3:0], mag(x) = {x,1'b0} zero-extended to OUT_W.
REQ-021 Triangle: q=0 -> mag(f); q=1 -> mag(~f); q=2 -> -mag(f); q=3 -> -mag(~f); range -(2^(OUT_W-1)-2)..+(2^(OUT_W-1)-2).
REQ-022 Sawtooth: T with MSB inverted (T=0 -> -2^(OUT_W-1), T=all ones -> 2^(OUT_W-1)-1).
REQ-023 Reverse sawtooth: bitwise NOT of the sawtooth value.
REQ-024 Square: +(2^(OUT_W-1)-1) when p MSB=0, else -(2^(OUT_W-1)-1).
REQ-025 wave_out SHALL register the sample of the current phase and act_mode every cycle (latency 1 from phase register); out_valid SHALL register en & ~phase_clr.
REQ-026 act_ftw=0 with en=1 SHALL hold phase and produce no wrap; act_ftw wrap-around arithmetic is modulo 2^PHASE_W with no saturation.

Reset
REQ-027 On an edge with rst=1: phase, act_ftw, pend_ftw = 0; act_mode, pend_mode = 0; FSM = EMPTY; wave_out = 0; out_valid = 0; wrap = 0; cfg_ready = 1 from the following cycle.
REQ-028 rst SHALL override every other input; a pending configuration is discarded, not applied.

Verification (PHASE_W=16, OUT_W=8)
REQ-029 Hold rst=1 three cycles with cfg_valid=1 -> wave_out=0x00, out_valid=0, wrap=0, cfg_ready=1 after release, no config accepted during reset.
REQ-030 Load ftw=0x0100 mode 0 with en=0, then en=1 -> wave_out sequence 0x00,0x02..0x7E, 0x7E,0x7C..0x00, 0x00,0xFE..0x82, 0x82..0xFE, then wrap=1 once every 256 cycles.
REQ-031 Running ftw=0x0100, offer ftw=0x0200 mode 1 at phase 0x4000 -> cfg_ready=0 until wrap; first post-wrap sample step uses 0x0200, sawtooth 0x80,0x82..; cfg_ready returns to 1.
REQ-032 Mode 2, ftw=0x0100 -> 0x7F for 128 samples, 0x81 for 128 samples; mode 3 at phase 0 -> 0x7F.
REQ-033 Offer config exactly on a wrap edge -> not applied there; applied at next wrap; assert phase_clr with pending config -> phase=0 and config applied same edge.
REQ-034 Assert rst with config PENDING at phase 0x8000 -> all outputs 0, act_ftw=0, pending config lost, en=1 afterwards produces constant 0x00 with no wrap.

Source files
------------

// File: rtl/wave_nco.sv
// Numerically controlled oscillator with a phase accumulator, four waveform shapes and
// a single-entry configuration buffer that is applied only at safe phase points.
module wave_nco #(
  parameter int PHASE_W = 16,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic [1:0]         cfg_mode,
  output logic [OUT_W-1:0]   wave_out,
  output logic               out_valid,
  output logic               wrap
);

  typedef enum logic {EMPTY = 1'b0, PENDING = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, act_ftw_reg, pend_ftw_reg;
  logic [1:0]         act_mode_reg, pend_mode_reg;
  logic [PHASE_W:0]   sum;
  logic               wrap_ev, accept, apply;

  logic [OUT_W-1:0]   t, mag_f, mag_nf, saw, sample;
  logic [OUT_W-3:0]   f;

  assign sum     = {1'b0, phase_reg} + {1'b0, act_ftw_reg};
  assign wrap_ev = en & ~phase_clr & sum[PHASE_W];
  assign accept  = cfg_valid & cfg_ready;

  // Config FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  // Config FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = PENDING;
      PENDING: if (apply)  state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Config FSM: outputs. A pending config lands only where the phase step is
  // discontinuous anyway (wrap, clear) or the accumulator is idle.
  always_comb begin
    cfg_ready = (state_reg == EMPTY);
    apply     = (state_reg == PENDING) & (wrap_ev | phase_clr | ~en);
  end

  always_comb begin
    t      = phase_reg[PHASE_W-1 -: OUT_W];
    f      = t[OUT_W-3:0];
    mag_f  = {1'b0, f, 1'b0};
    mag_nf = {1'b0, ~f, 1'b0};
    saw    = {~t[OUT_W-1], t[OUT_W-2:0]};
    sample = '0;
    case (act_mode_reg)
      2'd0: begin
        case (t[OUT_W-1:OUT_W-2])
          2'd0:    sample = mag_f;
          2'd1:    sample = mag_nf;
          2'd2:    sample = -mag_f;
          default: sample = -mag_nf;
        endcase
      end
      2'd1: sample = saw;
      2'd2: sample = phase_reg[PHASE_W-1] ? {1'b1, {(OUT_W-2){1'b0}}, 1'b1}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
      default: sample = ~saw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg     <= '0;
      act_ftw_reg   <= '0;
      act_mode_reg  <= '0;
      pend_ftw_reg  <= '0;
      pend_mode_reg <= '0;
      wave_out      <= '0;
      out_valid     <= 1'b0;
      wrap          <= 1'b0;
    end else begin
      // The increment on an applying edge still uses the old tuning word.
      if (phase_clr)  phase_reg <= '0;
      else if (en)    phase_reg <= sum[PHASE_W-1:0];
      if (accept) begin
        pend_ftw_reg  <= cfg_ftw;
        pend_mode_reg <= cfg_mode;
      end
      if (apply) begin
        act_ftw_reg  <= pend_ftw_reg;
        act_mode_reg <= pend_mode_reg;
      end
      wave_out  <= sample;
      out_valid <= en & ~phase_clr;
      wrap      <= wrap_ev;
    end
  end

endmodule

// File: tb/tb_wave_nco.sv
// Self-checking bench for wave_nco (PHASE_W=16, OUT_W=8): fixed vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_wave_nco;

  logic        clk, rst, en, phase_clr, cfg_valid, cfg_ready;
  logic [15:0] cfg_ftw;
  logic [1:0]  cfg_mode;
  logic [7:0]  wave_out;
  logic        out_valid, wrap;

  int ncmp = 0;
  int nbad = 0;

  // behavioural model state
  int m_phase, m_ftw, m_mode, m_pftw, m_pmode, m_wave;
  bit m_pend, m_valid, m_wrap;

  wave_nco #(.PHASE_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw),
    .cfg_mode(cfg_mode), .wave_out(wave_out), .out_valid(out_valid), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waveform value from the top 8 phase bits, as plain signed arithmetic.
  function automatic int model_sample(int p, int mode);
    int t;
    int v;
    t = p / 256;
    case (mode)
      0: begin
        if (t < 64)       v = 2 * t;
        else if (t < 128) v = 2 * (127 - t);
        else if (t < 192) v = -2 * (t - 128);
        else              v = -2 * (255 - t);
      end
      1: v = t - 128;
      2: v = (p < 32768) ? 127 : -127;
      default: v = 127 - t;
    endcase
    return v & 255;
  endfunction

  task automatic model_edge();
    bit wev, upd;
    int old_ftw;
    if (rst) begin
      m_phase = 0; m_ftw = 0; m_mode = 0; m_pftw = 0; m_pmode = 0;
      m_pend = 0; m_wave = 0; m_valid = 0; m_wrap = 0;
      return;
    end
    old_ftw = m_ftw;
    wev     = en && !phase_clr && (m_phase + old_ftw >= 65536);
    m_wave  = model_sample(m_phase, m_mode);
    m_valid = en && !phase_clr;
    m_wrap  = wev;
    upd     = m_pend && (wev || phase_clr || !en);
    if (upd) begin
      m_ftw = m_pftw; m_mode = m_pmode; m_pend = 0;
    end else if (!m_pend && cfg_valid) begin
      m_pftw = int'(cfg_ftw); m_pmode = int'(cfg_mode); m_pend = 1;
    end
    if (phase_clr) m_phase = 0;
    else if (en)   m_phase = (m_phase + old_ftw) % 65536;
  endtask

  task automatic check_eq(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare all outputs 1ns later.
  task automatic step(input bit r, input bit e, input bit c, input bit v,
                      input int ftw, input int mode);
    rst = r; en = e; phase_clr = c; cfg_valid = v;
    cfg_ftw = ftw[15:0]; cfg_mode = mode[1:0];
    @(posedge clk);
    model_edge();
    #1;
    ncmp++;
    if (wave_out !== m_wave[7:0] || out_valid !== m_valid || wrap !== m_wrap ||
        cfg_ready !== !m_pend) begin
      nbad++;
      $display("FAIL model t=%0t wave=%h/%h valid=%b/%b wrap=%b/%b ready=%b/%b",
               $time, wave_out, m_wave[7:0], out_valid, m_valid, wrap, m_wrap,
               cfg_ready, !m_pend);
    end
  endtask

  typedef struct {
    bit r, e, c, v;
    int ftw, mode;
    int wave;
    bit valid, wrp, rdy;
  } vec_t;

  vec_t tbl[14];
  int   wraps;
  bit   seen;

  initial begin
    tbl[0]  = '{0,0,0,1,'h4000,0, 'h00,0,0,0};
    tbl[1]  = '{0,0,0,0,'h0000,0, 'h00,0,0,1};
    tbl[2]  = '{0,1,0,0,'h0000,0, 'h00,1,0,1};
    tbl[3]  = '{0,1,0,0,'h0000,0, 'h7E,1,0,1};
    tbl[4]  = '{0,1,0,0,'h0000,0, 'h00,1,0,1};
    tbl[5]  = '{0,1,0,0,'h0000,0, 'h82,1,1,1};
    tbl[6]  = '{0,0,0,1,'h8000,2, 'h00,0,0,0};
    tbl[7]  = '{0,1,0,0,'h0000,0, 'h00,1,0,0};
    tbl[8]  = '{0,1,0,0,'h0000,0, 'h7E,1,0,0};
    tbl[9]  = '{0,1,1,0,'h0000,0, 'h00,0,0,1};
    tbl[10] = '{0,1,0,0,'h0000,0, 'h7F,1,0,1};
    tbl[11] = '{0,1,0,0,'h0000,0, 'h81,1,1,1};
    tbl[12] = '{0,1,0,0,'h0000,0, 'h7F,1,0,1};
    tbl[13] = '{1,1,0,1,'h1234,3, 'h00,0,0,1};

    // Reset held three cycles with a config offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 'h1234, 1);
    check_eq("rst_wave", int'(wave_out), 0);
    check_eq("rst_ready", int'(cfg_ready), 1);
    step(0, 1, 0, 0, 0, 0);
    check_eq("rst_no_cfg_wave", int'(wave_out), 0);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].ftw, tbl[i].mode);
      ncmp++;
      if (wave_out !== tbl[i].wave[7:0] || out_valid !== tbl[i].valid ||
          wrap !== tbl[i].wrp || cfg_ready !== tbl[i].rdy) begin
        nbad++;
        $display("FAIL vec%0d wave=%h/%h valid=%b/%b wrap=%b/%b ready=%b/%b", i,
                 wave_out, tbl[i].wave[7:0], out_valid, tbl[i].valid, wrap, tbl[i].wrp,
                 cfg_ready, tbl[i].rdy);
      end
    end

    // Triangle at ftw 0x0100: full period twice, one wrap per 256 cycles.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 'h0100, 0);
    step(0, 0, 0, 0, 0, 0);
    wraps = 0;
    for (int i = 0; i < 512; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (i == 64) check_eq("tri_peak", int'(wave_out), 'h7E);
      if (wrap) wraps++;
    end
    check_eq("tri_wraps", wraps, 2);

    // Offer a new config mid-period; it must wait for the wrap.
    while (m_phase != 'h4000) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h0200, 1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (wrap) seen = 1;
      else check_eq("wait_ready_low", int'(cfg_ready), 0);
    end
    check_eq("wrap_seen", int'(seen), 1);
    check_eq("ready_back", int'(cfg_ready), 1);
    step(0, 1, 0, 0, 0, 0);
    check_eq("saw_first", int'(wave_out), 'h80);
    step(0, 1, 0, 0, 0, 0);
    check_eq("saw_second", int'(wave_out), 'h82);

    // Config offered on the wrap edge itself is held until the following wrap.
    while (m_phase != 'hFE00) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h0100, 2);
    check_eq("onwrap_wrap", int'(wrap), 1);
    check_eq("onwrap_pending", int'(cfg_ready), 0);
    step(0, 1, 0, 0, 0, 0);
    check_eq("onwrap_still_saw", int'(wave_out), 'h80);
    for (int i = 0; i < 130; i++) step(0, 1, 0, 0, 0, 0);
    check_eq("applied_next_wrap", int'(cfg_ready), 1);
    step(0, 1, 0, 0, 0, 0);
    check_eq("square_hi", int'(wave_out), 'h7F);

    // phase_clr with a pending config clears phase and applies it at once.
    step(0, 1, 0, 1, 'h0300, 3);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_eq("clr_ready", int'(cfg_ready), 1);
    step(0, 1, 0, 0, 0, 0);
    check_eq("clr_rev_saw", int'(wave_out), 'h7F);

    // Reset with a pending config at phase 0x8000 discards it.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 'h0100, 0);
    step(0, 0, 0, 0, 0, 0);
    while (m_phase != 'h7F00) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 'h0700, 1);
    step(1, 1, 0, 0, 0, 0);
    check_eq("rst_pend_wave", int'(wave_out), 0);
    check_eq("rst_pend_ready", int'(cfg_ready), 1);
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, 0, 0, 0);
      if (wave_out != 8'h00 || wrap) wraps++;
    end
    check_eq("zero_ftw_static", wraps, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2047))
                                       : int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end

endmodule
